// File: rtl/div_wb_queue_pkg.sv
// Shared widths and the entry record for the divider writeback queue.
// The machine widths here stand in for the values normally taken from machine.vh.
package div_wb_queue_pkg;

   localparam int M_WIDTH        = 32;
   localparam int LG_ROB_ENTRIES = 6;
   localparam int LG_PRF_ENTRIES = 7;

   typedef struct packed {
      logic [M_WIDTH-1:0]        data;
      logic [LG_ROB_ENTRIES-1:0] robPtr;
      logic [LG_PRF_ENTRIES-1:0] prfPtr;
   } div_wb_entry_t;

endpackage

// File: rtl/div_wb_queue.sv
// Result FIFO between the iterative divider and the shared writeback port.
// Issue credits cover queued and in-flight divides, so a finished result always has a slot.
module div_wb_queue
   import div_wb_queue_pkg::*;
#(
   parameter int LG_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      div_start,
   input  logic                      div_complete,
   input  logic [M_WIDTH-1:0]        div_y,
   input  logic [LG_ROB_ENTRIES-1:0] div_rob_ptr,
   input  logic [LG_PRF_ENTRIES-1:0] div_prf_ptr,
   input  logic                      wb_slot_used,
   output logic                      can_start,
   output logic                      wb_valid,
   output logic [M_WIDTH-1:0]        wb_data,
   output logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr,
   output logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr,
   output logic [LG_DEPTH:0]         occupancy
);

   localparam int DEPTH = 1 << LG_DEPTH;
   localparam logic [LG_DEPTH:0]   DepthCount = (LG_DEPTH+1)'(DEPTH);
   localparam logic [LG_DEPTH+1:0] DepthExt   = (LG_DEPTH+2)'(DEPTH);

   div_wb_entry_t             entries_q [DEPTH];
   div_wb_entry_t             entries_d [DEPTH];
   logic [LG_DEPTH-1:0]       head_q, head_d;
   logic [LG_DEPTH-1:0]       tail_q, tail_d;
   logic [LG_DEPTH:0]         count_q, count_d;
   logic [LG_DEPTH:0]         inflight_q, inflight_d;
   logic [LG_DEPTH+1:0]       creditSum;
   logic                      wbFire;
   div_wb_entry_t             headEntry;

   // Next-state for storage, pointers and the credit counter; outputs come only from registers.
   always_comb begin
      entries_d  = entries_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      inflight_d = inflight_q;

      wb_valid  = (count_q != '0);
      wbFire    = wb_valid && !wb_slot_used;
      headEntry = wb_valid ? entries_q[head_q] : '0;

      if (div_complete) begin
         entries_d[tail_q] = '{data: div_y, robPtr: div_rob_ptr, prfPtr: div_prf_ptr};
         tail_d = tail_q + LG_DEPTH'(1);
      end
      if (wbFire) begin
         head_d = head_q + LG_DEPTH'(1);
      end

      unique case ({div_complete, wbFire})
         2'b10:   count_d = count_q + (LG_DEPTH+1)'(1);
         2'b01:   count_d = count_q - (LG_DEPTH+1)'(1);
         default: count_d = count_q;
      endcase

      unique case ({div_start, div_complete})
         2'b10:   inflight_d = inflight_q + (LG_DEPTH+1)'(1);
         2'b01:   inflight_d = inflight_q - (LG_DEPTH+1)'(1);
         default: inflight_d = inflight_q;
      endcase

      creditSum  = {1'b0, count_q} + {1'b0, inflight_q};
      can_start  = (creditSum < DepthExt);
      wb_data    = headEntry.data;
      wb_rob_ptr = headEntry.robPtr;
      wb_prf_ptr = headEntry.prfPtr;
      occupancy  = count_q;
   end

   // All state clears on the shared synchronous reset, including the in-flight credits.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         inflight_q <= '0;
      end else begin
         entries_q  <= entries_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
      end
   end

   // Protocol violations from the divider or issue logic; there is no recovery path.
   assert property (@(posedge clk) disable iff (reset)
      !(div_complete && (count_q == DepthCount) && !wbFire));
   assert property (@(posedge clk) disable iff (reset)
      !(div_start && !can_start));
   assert property (@(posedge clk) disable iff (reset)
      !(div_complete && (inflight_q == '0)));

endmodule

// File: tb/tb_div_wb_queue.sv
// Directed bench for div_wb_queue: reset, single op, backpressure, full-credit push+pop,
// credit accounting, pointer wrap and mid-operation reset.
module tb_div_wb_queue;
   import div_wb_queue_pkg::*;

   logic                      clk;
   logic                      reset;
   logic                      div_start;
   logic                      div_complete;
   logic [M_WIDTH-1:0]        div_y;
   logic [LG_ROB_ENTRIES-1:0] div_rob_ptr;
   logic [LG_PRF_ENTRIES-1:0] div_prf_ptr;
   logic                      wb_slot_used;
   logic                      can_start;
   logic                      wb_valid;
   logic [M_WIDTH-1:0]        wb_data;
   logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr;
   logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr;
   logic [2:0]                occupancy;

   int checks = 0;
   int errors = 0;

   div_wb_queue #(.LG_DEPTH(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .div_start    (div_start),
      .div_complete (div_complete),
      .div_y        (div_y),
      .div_rob_ptr  (div_rob_ptr),
      .div_prf_ptr  (div_prf_ptr),
      .wb_slot_used (wb_slot_used),
      .can_start    (can_start),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .wb_rob_ptr   (wb_rob_ptr),
      .wb_prf_ptr   (wb_prf_ptr),
      .occupancy    (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      div_start    = 1'b0;
      div_complete = 1'b0;
      div_y        = '0;
      div_rob_ptr  = '0;
      div_prf_ptr  = '0;
   endtask

   task automatic startOne();
      div_start = 1'b1;
      tick();
      div_start = 1'b0;
   endtask

   task automatic completeOne(input logic [M_WIDTH-1:0] y);
      div_complete = 1'b1;
      div_y        = y;
      div_rob_ptr  = y[LG_ROB_ENTRIES-1:0];
      div_prf_ptr  = y[LG_PRF_ENTRIES-1:0];
      tick();
      idleInputs();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wb_slot_used = 1'b0;
      idleInputs();
      tick();
      tick();
      reset = 1'b0;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid got %0h want 0", wb_valid); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("[TB] FAIL reset_occupancy got %0d want 0", occupancy); end
      checks++; if (can_start !== 1'b1) begin errors++; $display("[TB] FAIL reset_can_start got %0h want 1", can_start); end
      checks++; if (wb_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_wb_data got %0h want 0", wb_data); end
   endtask

   task automatic test_single_op();
      wb_slot_used = 1'b0;
      startOne();
      checks++; if (can_start !== 1'b1) begin errors++; $display("[TB] FAIL single_can_start got %0h want 1", can_start); end
      repeat (4) tick();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_no_bypass got %0h want 0", wb_valid); end
      div_complete = 1'b1;
      div_y        = 32'h7;
      div_rob_ptr  = 6'd3;
      div_prf_ptr  = 7'd9;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_complete_cycle got %0h want 0", wb_valid); end
      tick();
      idleInputs();
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_wb_valid got %0h want 1", wb_valid); end
      checks++; if (wb_data !== 32'h7) begin errors++; $display("[TB] FAIL single_wb_data got %0h want 7", wb_data); end
      checks++; if (wb_rob_ptr !== 6'd3) begin errors++; $display("[TB] FAIL single_rob got %0d want 3", wb_rob_ptr); end
      checks++; if (wb_prf_ptr !== 7'd9) begin errors++; $display("[TB] FAIL single_prf got %0d want 9", wb_prf_ptr); end
      checks++; if (occupancy !== 3'd1) begin errors++; $display("[TB] FAIL single_occ1 got %0d want 1", occupancy); end
      tick();
      checks++; if (occupancy !== 3'd0) begin errors++; $display("[TB] FAIL single_occ0 got %0d want 0", occupancy); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drained got %0h want 0", wb_valid); end
   endtask

   task automatic test_backpressure();
      wb_slot_used = 1'b1;
      for (int i = 0; i < 4; i++) startOne();
      checks++; if (can_start !== 1'b0) begin errors++; $display("[TB] FAIL bp_credit_exhausted got %0h want 0", can_start); end
      for (int i = 1; i <= 4; i++) completeOne(32'(i));
      tick();
      tick();
      checks++; if (occupancy !== 3'd4) begin errors++; $display("[TB] FAIL bp_occupancy got %0d want 4", occupancy); end
      checks++; if (can_start !== 1'b0) begin errors++; $display("[TB] FAIL bp_can_start got %0h want 0", can_start); end
      checks++; if (wb_data !== 32'h1) begin errors++; $display("[TB] FAIL bp_head_stable got %0h want 1", wb_data); end
      wb_slot_used = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (wb_valid !== 1'b1 || wb_data !== 32'(i)) begin errors++; $display("[TB] FAIL bp_drain_order valid %0h data %0h want 1 %0h", wb_valid, wb_data, i); end
         tick();
      end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("[TB] FAIL bp_empty got %0d want 0", occupancy); end
      checks++; if (can_start !== 1'b1) begin errors++; $display("[TB] FAIL bp_credit_back got %0h want 1", can_start); end
   endtask

   task automatic test_push_pop_full();
      // Credits reserve the last slot for the pending divide; it completes while the head fires.
      wb_slot_used = 1'b1;
      for (int i = 0; i < 3; i++) startOne();
      for (int i = 0; i < 3; i++) completeOne(32'h21 + 32'(i));
      startOne();
      checks++; if (can_start !== 1'b0) begin errors++; $display("[TB] FAIL pp_can_start got %0h want 0", can_start); end
      wb_slot_used = 1'b0;
      checks++; if (wb_data !== 32'h21) begin errors++; $display("[TB] FAIL pp_head got %0h want 21", wb_data); end
      completeOne(32'h25);
      checks++; if (occupancy !== 3'd3) begin errors++; $display("[TB] FAIL pp_occupancy got %0d want 3", occupancy); end
      checks++; if (wb_data !== 32'h22) begin errors++; $display("[TB] FAIL pp_order0 got %0h want 22", wb_data); end
      tick();
      checks++; if (wb_data !== 32'h23) begin errors++; $display("[TB] FAIL pp_order1 got %0h want 23", wb_data); end
      tick();
      checks++; if (wb_data !== 32'h25 || wb_rob_ptr !== 6'h25) begin errors++; $display("[TB] FAIL pp_order2 got %0h/%0h want 25/25", wb_data, wb_rob_ptr); end
      tick();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL pp_empty got %0h want 0", wb_valid); end
   endtask

   task automatic test_credit();
      wb_slot_used = 1'b1;
      for (int i = 0; i < 3; i++) startOne();
      for (int i = 0; i < 3; i++) completeOne(32'h31 + 32'(i));
      startOne();
      checks++; if (can_start !== 1'b0) begin errors++; $display("[TB] FAIL cr_blocked got %0h want 0", can_start); end
      wb_slot_used = 1'b0;
      tick();
      wb_slot_used = 1'b1;
      checks++; if (can_start !== 1'b1) begin errors++; $display("[TB] FAIL cr_restored got %0h want 1", can_start); end
      checks++; if (occupancy !== 3'd2) begin errors++; $display("[TB] FAIL cr_occ2 got %0d want 2", occupancy); end
      div_start = 1'b1;
      completeOne(32'h34);
      div_start = 1'b0;
      checks++; if (occupancy !== 3'd3) begin errors++; $display("[TB] FAIL cr_occ3 got %0d want 3", occupancy); end
      checks++; if (can_start !== 1'b0) begin errors++; $display("[TB] FAIL cr_inflight_held got %0h want 0", can_start); end
      completeOne(32'h35);
      checks++; if (occupancy !== 3'd4) begin errors++; $display("[TB] FAIL cr_occ4 got %0d want 4", occupancy); end
      wb_slot_used = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (wb_data !== 32'h32 + 32'(i)) begin errors++; $display("[TB] FAIL cr_drain got %0h want %0h", wb_data, 32'h32 + 32'(i)); end
         tick();
      end
      checks++; if (can_start !== 1'b1 || occupancy !== 3'd0) begin errors++; $display("[TB] FAIL cr_idle got %0h/%0d want 1/0", can_start, occupancy); end
   endtask

   task automatic test_wrap_reset();
      wb_slot_used = 1'b0;
      for (int i = 0; i < 9; i++) begin
         startOne();
         completeOne(32'h40 + 32'(i));
         checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h40 + 32'(i)) begin errors++; $display("[TB] FAIL wrap_entry%0d valid %0h data %0h", i, wb_valid, wb_data); end
         tick();
      end
      wb_slot_used = 1'b1;
      startOne();
      startOne();
      completeOne(32'h51);
      completeOne(32'h52);
      checks++; if (occupancy !== 3'd2) begin errors++; $display("[TB] FAIL wrap_held got %0d want 2", occupancy); end
      reset = 1'b1;
      tick();
      checks++; if (occupancy !== 3'd0 || wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_empty got %0d/%0h want 0/0", occupancy, wb_valid); end
      checks++; if (can_start !== 1'b1) begin errors++; $display("[TB] FAIL rst_can_start got %0h want 1", can_start); end
      checks++; if (wb_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_wb_data got %0h want 0", wb_data); end
      reset = 1'b0;
      wb_slot_used = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_backpressure();
      test_push_pop_full();
      test_credit();
      test_wrap_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
